// File: rtl/gf_exp_ctrl_if.sv
// rtl/gf_exp_ctrl_if.sv - request/response handshake bundle for gf_exp_ctrl
//
// Request side : in_valid/in_ready with in_base, in_exp, in_polyn_grade, in_polyn_red
// Response side: out_valid/out_ready with out_result
// modport slave  : the sequencer (accepts requests, produces results)
// modport master : the requester / result consumer
interface gf_exp_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int GRADE_W = $clog2(DATA_WIDTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_base;
  logic [DATA_WIDTH-1:0] in_exp;
  logic [GRADE_W-1:0]    in_polyn_grade;
  logic [DATA_WIDTH:0]   in_polyn_red;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;

  modport master (
    output in_valid, in_base, in_exp, in_polyn_grade, in_polyn_red, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_base, in_exp, in_polyn_grade, in_polyn_red, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/gf_exp_ctrl.sv
// rtl/gf_exp_ctrl.sv - GF(2^m) base^exp sequencer driving an external cl_modules datapath
//
// Square-and-multiply, MSB first. Every step is one carry-less multiply cycle
// followed by one reduce cycle on the shared combinational datapath.
// Optional feature macro: GF_EXP_SKIP_LZ_EN (start at the MSB set bit of the
// exponent; exp==0 completes straight from accept).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   io (slave)      request in_* / response out_* handshakes
//   busy            high in every state except IDLE
//   dp_red_funct    0 = multiply, 1 = reduce
//   dp_carry_option always 0 (carry-less)
//   dp_polyn_grade  latched degree of P (0 in IDLE)
//   dp_polyn_red_in latched P (0 in IDLE)
//   dp_reduc_in     product to reduce (reduce cycles only)
//   dp_a, dp_b      multiplier operands (multiply cycles only)
//   dp_out          reduced value from datapath
//   dp_mult_out     raw 2*DW product from datapath
module gf_exp_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  gf_exp_ctrl_if.slave                io,
  output logic                        busy,
  output logic                        dp_red_funct,
  output logic                        dp_carry_option,
  output logic [$clog2(DATA_WIDTH):0] dp_polyn_grade,
  output logic [DATA_WIDTH:0]         dp_polyn_red_in,
  output logic [2*DATA_WIDTH-1:0]     dp_reduc_in,
  output logic [DATA_WIDTH-1:0]       dp_a,
  output logic [DATA_WIDTH-1:0]       dp_b,
  input  logic [DATA_WIDTH-1:0]       dp_out,
  input  logic [2*DATA_WIDTH-1:0]     dp_mult_out
);
  localparam int IW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, SQ_MUL, SQ_RED, ML_MUL, ML_RED, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] base_r;
  logic [DATA_WIDTH-1:0] exp_r;
  logic [IW-1:0]         idx;

  assign dp_carry_option = 1'b0;

`ifdef GF_EXP_SKIP_LZ_EN
  function automatic logic [IW-1:0] msb_idx(input logic [DATA_WIDTH-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (v[i]) msb_idx = IW'(i);
  endfunction
`endif

  // The accumulator is never stored separately: after a reduce it is carried
  // forward in dp_a/dp_b for the next multiply, or in out_result when done.
  // dp_reduc_in doubles as the product register between multiply and reduce.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      base_r          <= '0;
      exp_r           <= '0;
      idx             <= '0;
      busy            <= 1'b0;
      io.in_ready     <= 1'b1;
      io.out_valid    <= 1'b0;
      io.out_result   <= '0;
      dp_red_funct    <= 1'b0;
      dp_polyn_grade  <= '0;
      dp_polyn_red_in <= '0;
      dp_reduc_in     <= '0;
      dp_a            <= '0;
      dp_b            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            base_r          <= io.in_base;
            exp_r           <= io.in_exp;
            dp_polyn_grade  <= io.in_polyn_grade;
            dp_polyn_red_in <= io.in_polyn_red;
            busy            <= 1'b1;
            io.in_ready     <= 1'b0;
`ifdef GF_EXP_SKIP_LZ_EN
            if (io.in_exp == '0) begin
              state         <= DONE;
              io.out_valid  <= 1'b1;
              io.out_result <= DATA_WIDTH'(1);
            end else begin
              idx   <= msb_idx(io.in_exp);
              state <= SQ_MUL;
              dp_a  <= DATA_WIDTH'(1);
              dp_b  <= DATA_WIDTH'(1);
            end
`else
            idx   <= IW'(DATA_WIDTH - 1);
            state <= SQ_MUL;
            dp_a  <= DATA_WIDTH'(1);
            dp_b  <= DATA_WIDTH'(1);
`endif
          end
        end

        SQ_MUL, ML_MUL: begin
          dp_reduc_in  <= dp_mult_out;
          dp_red_funct <= 1'b1;
          dp_a         <= '0;
          dp_b         <= '0;
          state        <= (state == SQ_MUL) ? SQ_RED : ML_RED;
        end

        SQ_RED, ML_RED: begin
          dp_reduc_in  <= '0;
          dp_red_funct <= 1'b0;
          if (state == SQ_RED && exp_r[idx]) begin
            state <= ML_MUL;
            dp_a  <= dp_out;
            dp_b  <= base_r;
          end else if (idx == '0) begin
            state         <= DONE;
            io.out_valid  <= 1'b1;
            io.out_result <= dp_out;
          end else begin
            idx   <= idx - 1'b1;
            state <= SQ_MUL;
            dp_a  <= dp_out;
            dp_b  <= dp_out;
          end
        end

        DONE: begin
          if (io.out_ready) begin
            state           <= IDLE;
            io.out_valid    <= 1'b0;
            io.in_ready     <= 1'b1;
            busy            <= 1'b0;
            dp_polyn_grade  <= '0;
            dp_polyn_red_in <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
